ow_presence_responder: RTL
==========================

Name: ow_presence_responder

Overview:
- 1-Wire slave-side responder: the other end of the master reset sequence.
- Watches the shared open-drain bus and detects a master reset pulse (bus low for at least RESET_MIN_US).
- After the master releases the bus, waits PRES_WAIT_US, then pulls the bus low for PRES_LOW_US as the presence pulse.
- Flags completion to the slave's bit-slot logic.

Parameters:
- CLK_PER_US, 1: clock cycles per microsecond. All durations below are multiplied by this value.
- RESET_MIN_US, 480: minimum low time on the bus that is accepted as a reset pulse.
- PRES_WAIT_US, 30: delay from bus release to the start of the presence pulse.
- PRES_LOW_US, 120: length of the presence pulse.
- CNT_W, 16: width of the cycle counter. Must hold RESET_MIN_US*CLK_PER_US.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en_respond  input  1  enables the responder. When low, the block stays in IDLE.
- bus  input  1  raw 1-Wire bus level (1 = released/high).
- slave_pull_low  output  1  1 = drive the bus low (open-drain enable).
- reset_detected  output  1  one-cycle pulse when a valid reset pulse ends.
- presence_done  output  1  one-cycle pulse when the presence sequence completes.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - slave_pull_low=0, reset_detected=0, presence_done=0, busy=0.
  - Both synchronizer flops are set to 1.
  - An assertion mid-sequence releases the bus immediately.
- Input sync: bus passes through a 2-flop synchronizer giving bus_s. All decisions use bus_s, so there are 2 cycles of latency from the pin.
- Counter: a single CNT_W counter. It clears on every state entry and increments by 1 per clk. Comparisons use >= (threshold-1) so each timed state lasts exactly N cycles.
- IDLE:
  - busy=0.
  - If en_respond=1 and bus_s=0, go to LOW_MEAS with counter=1 (the first low cycle has been counted).
- LOW_MEAS:
  - Counts the cycles during which bus_s=0.
  - If bus_s returns to 1 before the count reaches RESET_MIN_US*CLK_PER_US, go to IDLE. This is an ordinary time slot, not a reset, so there is no pulse.
  - When the count reaches the threshold, go to WAIT_REL. The counter saturates there.
- WAIT_REL:
  - Holds for as long as bus_s=0. Long resets of any length are accepted.
  - On bus_s=1: assert reset_detected for 1 cycle and go to PRES_WAIT.
- PRES_WAIT:
  - Waits PRES_WAIT_US*CLK_PER_US cycles, then goes to PRES_DRIVE.
  - bus_s going low here (another device) is ignored.
  - If en_respond drops here, go to IDLE with no presence pulse.
- PRES_DRIVE:
  - slave_pull_low=1 for exactly PRES_LOW_US*CLK_PER_US cycles. It is registered and asserts on the cycle after the state is entered.
  - bus is ignored. en_respond is ignored once driving has started.
  - Then go to RECOVER with slave_pull_low=0.
- RECOVER:
  - Ignores bus_s for 2 cycles (synchronizer flush), then waits for bus_s=1. Other slaves may still be holding the bus low.
  - On bus_s=1: pulse presence_done for 1 cycle and go to IDLE.
- A new reset from the master that starts during PRES_WAIT is not tracked. The block re-arms only from IDLE.
- Outputs are registered. reset_detected and presence_done are never both high in the same cycle.

Test Plan:
1. Defaults, CLK_PER_US=1, en_respond=1.
   - Stimulus: bus low 480 cycles, then high.
   - Required: reset_detected pulses 2 cycles after the rise; slave_pull_low rises 30 (+1) cycles later and stays high exactly 120 cycles.
   - With the bench modelling the wired-AND: presence_done pulses 3 cycles after release.
2. Short low pulse.
   - Stimulus: bus low 479 cycles.
   - Required: no reset_detected, slave_pull_low stays 0, busy falls 2 cycles after the rise.
3. Long reset.
   - Stimulus: bus low 2000 cycles.
   - Required: a single reset_detected after release; presence timing identical to scenario 1.
4. Stretched bus.
   - Stimulus: a second slave holds the bus low 40 cycles beyond our presence pulse.
   - Required: presence_done occurs only after the bus goes high.
5. Reset mid-sequence.
   - Stimulus: rst_n=0 at cycle 50 of PRES_DRIVE.
   - Required: slave_pull_low=0 the same cycle (async); busy=0; the next valid 480-cycle low restarts the full sequence.
6. Disable.
   - Stimulus: en_respond=0 during a 480-cycle low; separately, en_respond dropped in PRES_WAIT.
   - Required: no response in the first case; return to IDLE with slave_pull_low never asserted in the second.

Source files
------------

// File: rtl/ow_presence_responder.sv
// 1-Wire slave presence responder: detects a master reset pulse on the bus and
// answers with a presence pulse, flagging reset detection and sequence completion.
module ow_presence_responder #(
    parameter int unsigned CLK_PER_US   = 1,
    parameter int unsigned RESET_MIN_US = 480,
    parameter int unsigned PRES_WAIT_US = 30,
    parameter int unsigned PRES_LOW_US  = 120,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_respond,
    input  logic bus,
    output logic slave_pull_low,
    output logic reset_detected,
    output logic presence_done,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOW_MEAS,
        WAIT_REL,
        PRES_WAIT,
        PRES_DRIVE,
        RECOVER
    } state_t;

    // Each timed state exits when the counter reaches (length - 1).
    localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(RESET_MIN_US * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(PRES_WAIT_US * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(PRES_LOW_US * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] FLUSH_LEN  = CNT_W'(2);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             bus_m, bus_s;
    logic             rd_next, done_next;

    // Synchronizer idles at the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_m <= 1'b1;
            bus_s <= 1'b1;
        end else begin
            bus_m <= bus;
            bus_s <= bus_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            slave_pull_low <= 1'b0;
            reset_detected <= 1'b0;
            presence_done  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            slave_pull_low <= (state == PRES_DRIVE);
            reset_detected <= rd_next;
            presence_done  <= done_next;
            busy           <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        rd_next    = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (en_respond && !bus_s) begin
                    state_next = LOW_MEAS;
                    cnt_next   = CNT_W'(1);
                end
            end
            LOW_MEAS: begin
                if (bus_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt >= LOW_LAST) begin
                    state_next = WAIT_REL;
                    cnt_next   = cnt;
                end
            end
            WAIT_REL: begin
                cnt_next = cnt;
                if (bus_s) begin
                    state_next = PRES_WAIT;
                    cnt_next   = '0;
                    rd_next    = 1'b1;
                end
            end
            PRES_WAIT: begin
                if (!en_respond) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt >= WAIT_LAST) begin
                    state_next = PRES_DRIVE;
                    cnt_next   = '0;
                end
            end
            PRES_DRIVE: begin
                if (cnt >= DRIVE_LAST) begin
                    state_next = RECOVER;
                    cnt_next   = '0;
                end
            end
            RECOVER: begin
                // Our own pull is still in the synchronizer for the first cycles.
                if (cnt >= FLUSH_LEN) begin
                    cnt_next = cnt;
                    if (bus_s) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule
